iob_write_buffer: RTL and testbench
===================================

IOB_WRITE_BUFFER -- requirements
Module: iob_write_buffer

Interface
REQ-001 Parameter: DEPTH, default 4; number of posted-write entries; SHALL be a power of two in 2..8.
REQ-002 Parameter: AW, default 23; word-address width (A[AW:1]).
REQ-003 Parameter: DW, default 16; data width.
REQ-004 FCLK  in  1  sole clock; all state changes on rising edge.
REQ-005 nRESin  in  1  asynchronous, active-low reset.
REQ-006 WrReq  in  1  FSB write request; held high until WrAck.
REQ-007 WrA  in  AW  write word address; WrD in DW write data; WrU, WrL in 1 each, active-high byte-lane enables.
REQ-008 WrAck  out  1  one-cycle pulse: write accepted.
REQ-009 RdClear  out  1  high when buffer empty and no IOB write outstanding.
REQ-010 IOWRREQ  out  1  IOB write request to the IOB master; IOA out AW, IOD out DW, IOU0/IOL0 out 1 each.
REQ-011 IODONE  in  1  one-cycle pulse: IOB cycle complete; IOBERR in 1, valid with IODONE.
REQ-012 Level  out  clog2(DEPTH+1)  occupied entries; Full out 1; Empty out 1.
REQ-013 ErrSticky  out  1  write bus-error flag; ErrClr in 1 clears it.

Function
REQ-014 Buffer SHALL be a circular FIFO of DEPTH entries {addr, data, U, L}; head/tail pointers wrap modulo DEPTH.
REQ-015 WrReq high at edge k, WrAck low, and (Level<DEPTH or pop at k) SHALL write tail entry at k and pulse WrAck for cycle k..k+1.
REQ-016 WrReq SHALL be ignored while WrAck is high; when Full with no pop, WrReq stalls with WrAck low.
REQ-017 Simultaneous push and pop at one edge SHALL leave Level unchanged, entry order preserved.
REQ-018 Issue FSM states IDLE, REQ, GAP: IDLE->REQ when not Empty; REQ->GAP on IODONE; GAP->IDLE unconditionally.
REQ-019 In REQ, IOWRREQ SHALL be high and IOA/IOD/IOU0/IOL0 SHALL present head entry, stable until IODONE.
REQ-020 On IODONE in REQ, head entry SHALL be popped; IOWRREQ low for at least the GAP cycle.
REQ-021 IODONE outside REQ SHALL be ignored.
REQ-022 IOBERR with IODONE SHALL still pop the entry and set ErrSticky; set wins over simultaneous ErrClr.
REQ-023 RdClear SHALL equal Empty AND state==IDLE, registered-free (combinational from state).
REQ-024 Full = (Level==DEPTH); Empty = (Level==0); Level never exceeds DEPTH nor underflows.

Reset
REQ-025 nRESin low SHALL immediately clear pointers, Level=0, state=IDLE, WrAck=0, IOWRREQ=0, ErrSticky=0, IOA/IOD=0, IOU0/IOL0=0, Empty=1, Full=0, RdClear=1.
REQ-026 Reset mid-cycle SHALL discard all buffered and in-flight writes; no partial pop afterwards.

Configuration
REQ-027 Macro IOB_WB_MERGE_EN: when defined, a write whose WrA equals the newest entry's address, where that entry is not the head in REQ/GAP, SHALL merge into it (enabled lanes overwrite data, U/L OR-ed), pulse WrAck, and leave Level unchanged.
REQ-028 Without IOB_WB_MERGE_EN, every accepted write SHALL allocate a new entry.

Verification
REQ-029 DEPTH=4, four writes A=0x580000..0x580003 while IODONE held low -> Level=4, Full=1, fifth WrReq stalls until first IODONE, then accepted next edge.
REQ-030 Write D=0x1234 U=1 L=0 into empty buffer -> IOWRREQ high two edges later with IOD=0x1234, IOU0=1, IOL0=0; IODONE -> Empty=1, RdClear=1 after GAP.
REQ-031 IODONE with IOBERR=1 -> entry popped, ErrSticky=1; ErrClr pulse -> ErrSticky=0; ErrClr with new IOBERR same edge -> ErrSticky=1.
REQ-032 Full buffer, WrReq and IODONE at same edge -> push and pop both occur, Level stays 4, order intact on drain.
REQ-033 With IOB_WB_MERGE_EN, two writes to 0x580010 (U=1 D=0xAB00, then L=1 D=0x00CD) while another entry is head -> Level rises by 1, issued IOD=0xABCD, IOU0=IOL0=1; without macro -> two entries.
REQ-034 nRESin pulsed low while IOWRREQ high with Level=3 -> IOWRREQ=0 immediately, Level=0, no further IOB requests.

Source files
------------

// File: rtl/iob_write_buffer.sv
// Posted-write buffer between the FSB write port and the IOB master: circular FIFO plus a three-state issue FSM.
// Define IOB_WB_MERGE_EN to merge a write into the newest entry when its word address matches.
module iob_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 23,
  parameter int DW    = 16
) (
  input  logic                         FCLK,
  input  logic                         nRESin,
  input  logic                         WrReq,
  input  logic [AW-1:0]                WrA,
  input  logic [DW-1:0]                WrD,
  input  logic                         WrU,
  input  logic                         WrL,
  output logic                         WrAck,
  output logic                         RdClear,
  output logic                         IOWRREQ,
  output logic [AW-1:0]                IOA,
  output logic [DW-1:0]                IOD,
  output logic                         IOU0,
  output logic                         IOL0,
  input  logic                         IODONE,
  input  logic                         IOBERR,
  output logic [$clog2(DEPTH+1)-1:0]   Level,
  output logic                         Full,
  output logic                         Empty,
  output logic                         ErrSticky,
  input  logic                         ErrClr
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int HW = DW / 2;

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t        state;
  logic [AW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          mem_u [DEPTH];
  logic          mem_l [DEPTH];
  logic [PW-1:0] head, tail, newest;
  logic          pop, take, push, merge, merge_hit;

  assign Empty   = (Level == '0);
  assign Full    = (Level == LW'(DEPTH));
  assign RdClear = Empty && (state == IDLE);
  assign pop     = (state == REQ) && IODONE;
  assign newest  = tail - PW'(1);

`ifdef IOB_WB_MERGE_EN
  // The head is never a merge target: the IOB output registers capture it as soon as it is non-empty.
  assign merge_hit = !Empty && (mem_a[newest] == WrA) && (newest != head);
`else
  assign merge_hit = 1'b0;
`endif

  assign take  = WrReq && !WrAck && (merge_hit || !Full || pop);
  assign push  = take && !merge_hit;
  assign merge = take && merge_hit;

  always_ff @(posedge FCLK) begin
    if (push) begin
      mem_a[tail] <= WrA;
      mem_d[tail] <= WrD;
      mem_u[tail] <= WrU;
      mem_l[tail] <= WrL;
    end else if (merge) begin
      if (WrU) mem_d[newest][DW-1:HW] <= WrD[DW-1:HW];
      if (WrL) mem_d[newest][HW-1:0]  <= WrD[HW-1:0];
      mem_u[newest] <= mem_u[newest] | WrU;
      mem_l[newest] <= mem_l[newest] | WrL;
    end
  end

  always_ff @(posedge FCLK or negedge nRESin) begin
    if (!nRESin) begin
      head      <= '0;
      tail      <= '0;
      Level     <= '0;
      WrAck     <= 1'b0;
      state     <= IDLE;
      IOWRREQ   <= 1'b0;
      IOA       <= '0;
      IOD       <= '0;
      IOU0      <= 1'b0;
      IOL0      <= 1'b0;
      ErrSticky <= 1'b0;
    end else begin
      WrAck <= take;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   Level <= Level + LW'(1);
        2'b01:   Level <= Level - LW'(1);
        default: Level <= Level;
      endcase

      if (pop && IOBERR) ErrSticky <= 1'b1;
      else if (ErrClr)   ErrSticky <= 1'b0;

      case (state)
        IDLE: begin
          if (!Empty) begin
            state   <= REQ;
            IOWRREQ <= 1'b1;
            IOA     <= mem_a[head];
            IOD     <= mem_d[head];
            IOU0    <= mem_u[head];
            IOL0    <= mem_l[head];
          end
        end
        REQ: begin
          if (IODONE) begin
            state   <= GAP;
            IOWRREQ <= 1'b0;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_write_buffer.sv
// Directed bench for iob_write_buffer (DEPTH=4, AW=23, DW=16); expected values are hand-derived.
module tb_iob_write_buffer;

  logic        FCLK = 1'b0;
  logic        nRESin;
  logic        WrReq, WrU, WrL, IODONE, IOBERR, ErrClr;
  logic [22:0] WrA;
  logic [15:0] WrD;
  logic        WrAck, RdClear, IOWRREQ, IOU0, IOL0, Full, Empty, ErrSticky;
  logic [22:0] IOA;
  logic [15:0] IOD;
  logic [2:0]  Level;

  int total = 0;
  int bad   = 0;

  iob_write_buffer #(.DEPTH(4), .AW(23), .DW(16)) dut (
    .FCLK(FCLK), .nRESin(nRESin), .WrReq(WrReq), .WrA(WrA), .WrD(WrD),
    .WrU(WrU), .WrL(WrL), .WrAck(WrAck), .RdClear(RdClear), .IOWRREQ(IOWRREQ),
    .IOA(IOA), .IOD(IOD), .IOU0(IOU0), .IOL0(IOL0), .IODONE(IODONE),
    .IOBERR(IOBERR), .Level(Level), .Full(Full), .Empty(Empty),
    .ErrSticky(ErrSticky), .ErrClr(ErrClr)
  );

  always #5 FCLK = ~FCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic write(input logic [31:0] a, input logic [15:0] d, input logic u, input logic l);
    int n;
    @(negedge FCLK);
    WrReq = 1'b1; WrA = a[22:0]; WrD = d; WrU = u; WrL = l;
    n = 0;
    do begin
      @(posedge FCLK); #1;
      n++;
    end while (!WrAck && n < 40);
    if (!WrAck) check("wrack_timeout", 32'(WrAck), 32'd1);
    WrReq = 1'b0;
  endtask

  task automatic serve(input logic [31:0] a, input logic [15:0] d, input logic u, input logic l,
                       input logic err, input logic clr);
    int n;
    n = 0;
    while (!IOWRREQ && n < 20) begin
      @(posedge FCLK); #1;
      n++;
    end
    check("req_seen", 32'(IOWRREQ), 32'd1);
    check("ioa", 32'(IOA), a);
    check("iod", 32'(IOD), 32'(d));
    check("iou", 32'(IOU0), 32'(u));
    check("iol", 32'(IOL0), 32'(l));
    @(negedge FCLK);
    IODONE = 1'b1; IOBERR = err; ErrClr = clr;
    @(posedge FCLK); #1;
    IODONE = 1'b0; IOBERR = 1'b0; ErrClr = 1'b0;
    check("req_drop", 32'(IOWRREQ), 32'd0);
  endtask

  initial begin
    nRESin = 1'b0; WrReq = 1'b0; WrA = '0; WrD = '0; WrU = 1'b0; WrL = 1'b0;
    IODONE = 1'b0; IOBERR = 1'b0; ErrClr = 1'b0;
    #12;
    check("rst_level", 32'(Level), 32'd0);
    check("rst_empty", 32'(Empty), 32'd1);
    check("rst_full", 32'(Full), 32'd0);
    check("rst_rdclear", 32'(RdClear), 32'd1);
    check("rst_iowrreq", 32'(IOWRREQ), 32'd0);
    check("rst_wrack", 32'(WrAck), 32'd0);
    check("rst_err", 32'(ErrSticky), 32'd0);
    check("rst_ioa", 32'(IOA), 32'd0);
    check("rst_iod", 32'(IOD), 32'd0);
    @(negedge FCLK); nRESin = 1'b1;

    // IODONE with IOBERR while idle must be ignored
    @(negedge FCLK); IODONE = 1'b1; IOBERR = 1'b1;
    @(posedge FCLK); #1; IODONE = 1'b0; IOBERR = 1'b0;
    check("stray_done_err", 32'(ErrSticky), 32'd0);
    check("stray_done_level", 32'(Level), 32'd0);

    // single write, issue and drain
    write(32'h000100, 16'h1234, 1'b1, 1'b0);
    check("w1_level", 32'(Level), 32'd1);
    check("w1_rdclear", 32'(RdClear), 32'd0);
    check("w1_req_early", 32'(IOWRREQ), 32'd0);
    @(posedge FCLK); #1;
    check("w1_req", 32'(IOWRREQ), 32'd1);
    check("w1_wrack_pulse", 32'(WrAck), 32'd0);
    serve(32'h000100, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
    check("w1_empty", 32'(Empty), 32'd1);
    check("w1_rdclear_gap", 32'(RdClear), 32'd0);
    @(posedge FCLK); #1;
    check("w1_rdclear_idle", 32'(RdClear), 32'd1);

    // bus error, clear, and set-wins-over-clear
    write(32'h000200, 16'h5555, 1'b1, 1'b1);
    serve(32'h000200, 16'h5555, 1'b1, 1'b1, 1'b1, 1'b0);
    check("err_set", 32'(ErrSticky), 32'd1);
    check("err_pop", 32'(Level), 32'd0);
    @(negedge FCLK); ErrClr = 1'b1;
    @(posedge FCLK); #1; ErrClr = 1'b0;
    check("err_clr", 32'(ErrSticky), 32'd0);
    write(32'h000201, 16'h6666, 1'b0, 1'b1);
    serve(32'h000201, 16'h6666, 1'b0, 1'b1, 1'b1, 1'b1);
    check("err_set_wins", 32'(ErrSticky), 32'd1);
    @(negedge FCLK); ErrClr = 1'b1;
    @(posedge FCLK); #1; ErrClr = 1'b0;
    repeat (2) @(posedge FCLK);
    #1;

    // fill to DEPTH, stall, then push+pop on the same edge
    for (int i = 0; i < 4; i++)
      write(32'h580000 + 32'(i), 16'h1000 + 16'(i), 1'b1, 1'b1);
    check("fill_level", 32'(Level), 32'd4);
    check("fill_full", 32'(Full), 32'd1);
    @(negedge FCLK);
    WrReq = 1'b1; WrA = 23'h580004; WrD = 16'h1004; WrU = 1'b1; WrL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge FCLK); #1;
      check("stall_wrack", 32'(WrAck), 32'd0);
    end
    check("stall_level", 32'(Level), 32'd4);
    check("head_ioa", 32'(IOA), 32'h580000);
    @(negedge FCLK); IODONE = 1'b1;
    @(posedge FCLK); #1; IODONE = 1'b0; WrReq = 1'b0;
    check("pushpop_wrack", 32'(WrAck), 32'd1);
    check("pushpop_level", 32'(Level), 32'd4);
    for (int i = 1; i < 5; i++)
      serve(32'h580000 + 32'(i), 16'h1000 + 16'(i), 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge FCLK);
    #1;
    check("drain_empty", 32'(Empty), 32'd1);
    check("drain_rdclear", 32'(RdClear), 32'd1);

    // same-address writes behind a busy head
    write(32'h580020, 16'h0001, 1'b1, 1'b1);
    write(32'h580010, 16'hAB00, 1'b1, 1'b0);
    write(32'h580010, 16'h00CD, 1'b0, 1'b1);
`ifdef IOB_WB_MERGE_EN
    check("merge_level", 32'(Level), 32'd2);
    serve(32'h580020, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
    serve(32'h580010, 16'hABCD, 1'b1, 1'b1, 1'b0, 1'b0);
`else
    check("nomerge_level", 32'(Level), 32'd3);
    serve(32'h580020, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
    serve(32'h580010, 16'hAB00, 1'b1, 1'b0, 1'b0, 1'b0);
    serve(32'h580010, 16'h00CD, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
    repeat (2) @(posedge FCLK);
    #1;
    check("merge_drain", 32'(Empty), 32'd1);

    // asynchronous reset with an outstanding request
    for (int i = 0; i < 3; i++)
      write(32'h000300 + 32'(i), 16'h7000 + 16'(i), 1'b1, 1'b1);
    check("pre_rst_level", 32'(Level), 32'd3);
    check("pre_rst_req", 32'(IOWRREQ), 32'd1);
    @(negedge FCLK); #2 nRESin = 1'b0;
    #1;
    check("arst_req", 32'(IOWRREQ), 32'd0);
    check("arst_level", 32'(Level), 32'd0);
    check("arst_rdclear", 32'(RdClear), 32'd1);
    nRESin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge FCLK); #1;
      check("post_rst_req", 32'(IOWRREQ), 32'd0);
    end
    check("post_rst_level", 32'(Level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
